// File: rtl/func_arbiter_pkg.sv
// Shared sizing helpers, default geometry and the dispatch record for the call scheduler.
package func_arbiter_pkg;

  function automatic int unsigned log2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

  localparam int unsigned PARENT_DEF     = 32;
  localparam int unsigned CHILD_DEF      = 64;
  localparam int unsigned THREAD_DEF     = 16;
  localparam int unsigned MAX_OUTST_DEF  = 4;
  localparam int unsigned LOG_PARENT_DEF = log2_min1(PARENT_DEF);
  localparam int unsigned LOG_CHILD_DEF  = log2_min1(CHILD_DEF);
  localparam int unsigned LOG_THREAD_DEF = log2_min1(THREAD_DEF);

  // Field widths follow the default geometry; the top is built with matching parameters.
  typedef struct packed {
    logic [LOG_PARENT_DEF-1:0] parent;
    logic [LOG_CHILD_DEF-1:0]  child;
    logic [LOG_THREAD_DEF-1:0] thread;
  } disp_rec_t;

endpackage

// File: rtl/call_dispatch_sched_if.sv
// Bundle of request, child, return and dispatch signals between callers and the scheduler.
interface call_dispatch_sched_if
  import func_arbiter_pkg::*;
#(
  parameter int unsigned PARENT = PARENT_DEF,
  parameter int unsigned CHILD  = CHILD_DEF,
  parameter int unsigned THREAD = THREAD_DEF
);
  localparam int unsigned LOG_PARENT = log2_min1(PARENT);
  localparam int unsigned LOG_CHILD  = log2_min1(CHILD);
  localparam int unsigned LOG_THREAD = log2_min1(THREAD);

  logic [PARENT-1:0]                 parent_req_i;
  logic [PARENT-1:0][LOG_CHILD-1:0]  parent_child_i;
  logic [PARENT-1:0][LOG_THREAD-1:0] parent_thread_i;
  logic [PARENT-1:0]                 parent_gnt_o;
  logic [CHILD-1:0]                  child_rdy_i;
  logic [CHILD-1:0]                  child_ap_done_i;
  logic                              ret_vld_i;
  logic [LOG_THREAD-1:0]             ret_thread_i;
  logic                              disp_vld_o;
  logic [LOG_PARENT-1:0]             disp_parent_o;
  logic [LOG_CHILD-1:0]              disp_child_o;
  logic [LOG_THREAD-1:0]             disp_thread_o;
  logic [CHILD-1:0]                  child_busy_o;
  logic [THREAD-1:0]                 ret_underflow_o;

  modport master (
    output parent_req_i, parent_child_i, parent_thread_i, child_rdy_i, child_ap_done_i,
           ret_vld_i, ret_thread_i,
    input  parent_gnt_o, disp_vld_o, disp_parent_o, disp_child_o, disp_thread_o,
           child_busy_o, ret_underflow_o
  );

  modport slave (
    input  parent_req_i, parent_child_i, parent_thread_i, child_rdy_i, child_ap_done_i,
           ret_vld_i, ret_thread_i,
    output parent_gnt_o, disp_vld_o, disp_parent_o, disp_child_o, disp_thread_o,
           child_busy_o, ret_underflow_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter
  import func_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 32,
  localparam int unsigned LOG_N = log2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [LOG_N-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [LOG_N-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin : p_pick
    int unsigned w_base;
    int unsigned w_p;
    w_base = 32'(ptr_i);
    w_p    = 0;
    gnt_o  = '0;
    idx_o  = '0;
    vld_o  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_p = (w_base + k) % N;
      if (!vld_o && req_i[LOG_N'(w_p)]) begin
        vld_o               = 1'b1;
        gnt_o[LOG_N'(w_p)]  = 1'b1;
        idx_o               = LOG_N'(w_p);
      end
    end
  end

endmodule

// File: rtl/call_dispatch_sched.sv
// Grants one eligible caller per cycle, tracks busy children and per-thread outstanding calls,
// and emits a registered dispatch record one cycle after each grant.
module call_dispatch_sched
  import func_arbiter_pkg::*;
#(
  parameter  int unsigned PARENT     = PARENT_DEF,
  parameter  int unsigned CHILD      = CHILD_DEF,
  parameter  int unsigned THREAD     = THREAD_DEF,
  parameter  int unsigned MAX_OUTST  = MAX_OUTST_DEF,
  localparam int unsigned LOG_PARENT = log2_min1(PARENT),
  localparam int unsigned LOG_CHILD  = log2_min1(CHILD),
  localparam int unsigned LOG_THREAD = log2_min1(THREAD),
  localparam int unsigned CNT_W      = cnt_w(MAX_OUTST)
) (
  input logic                 clk,
  input logic                 rst,
  call_dispatch_sched_if.slave bus
);

  logic [LOG_PARENT-1:0] r_rr_ptr;
  logic [CHILD-1:0]      r_busy;
  logic                  r_disp_vld;
  disp_rec_t             r_disp;

  logic [PARENT-1:0]     w_elig;
  logic [PARENT-1:0]     w_gnt;
  logic [LOG_PARENT-1:0] w_win;
  logic                  w_win_vld;
  logic                  w_fire;
  logic [LOG_CHILD-1:0]  w_win_child;
  logic [LOG_THREAD-1:0] w_win_thread;
  logic [LOG_PARENT-1:0] w_rr_next;
  logic [CHILD-1:0]      w_busy_set;
  logic [CNT_W-1:0]      w_outst [THREAD];
  logic [THREAD-1:0]     w_uflow;

  for (genvar p = 0; p < PARENT; p++) begin : g_elig
    assign w_elig[p] = bus.parent_req_i[p]
                    && !r_busy[bus.parent_child_i[p]]
                    && bus.child_rdy_i[bus.parent_child_i[p]]
                    && (w_outst[bus.parent_thread_i[p]] < CNT_W'(MAX_OUTST));
  end

  rr_arbiter #(
    .N (PARENT)
  ) u_rr_arbiter (
    .req_i (w_elig),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_win),
    .vld_o (w_win_vld)
  );

  // Grant is suppressed while reset is held so no caller consumes a request it cannot keep.
  assign w_fire           = w_win_vld && !rst;
  assign bus.parent_gnt_o = rst ? '0 : w_gnt;
  assign w_win_child      = bus.parent_child_i[w_win];
  assign w_win_thread     = bus.parent_thread_i[w_win];
  assign w_rr_next        = (w_win == LOG_PARENT'(PARENT - 1)) ? '0 : w_win + LOG_PARENT'(1);
  assign w_busy_set       = w_fire ? (CHILD'(1) << w_win_child) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_busy     <= '0;
      r_disp_vld <= 1'b0;
      r_disp     <= '0;
    end else begin
      r_busy     <= (r_busy & ~bus.child_ap_done_i) | w_busy_set;
      r_disp_vld <= w_fire;
      if (w_fire) begin
        r_rr_ptr      <= w_rr_next;
        r_disp.parent <= w_win;
        r_disp.child  <= w_win_child;
        r_disp.thread <= w_win_thread;
      end
    end
  end

  for (genvar t = 0; t < THREAD; t++) begin : g_thread
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_uf;

    assign w_inc = w_fire && (w_win_thread == LOG_THREAD'(t));
    assign w_dec = bus.ret_vld_i && (bus.ret_thread_i == LOG_THREAD'(t));

    // A grant and a return on the same thread cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_uf  <= 1'b0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        if (r_cnt == '0) begin
          r_uf <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end

    assign w_outst[t] = r_cnt;
    assign w_uflow[t] = r_uf;
  end

  assign bus.disp_vld_o      = r_disp_vld;
  assign bus.disp_parent_o   = r_disp.parent;
  assign bus.disp_child_o    = r_disp.child;
  assign bus.disp_thread_o   = r_disp.thread;
  assign bus.child_busy_o    = r_busy;
  assign bus.ret_underflow_o = w_uflow;

endmodule

// File: doc/call_dispatch_sched.md
CALL_DISPATCH_SCHED -- requirements
Module: call_dispatch_sched

Interface
REQ-001 SHALL take parameter PARENT, default 32, number of requesting parents.
REQ-002 SHALL take parameter CHILD, default 64, number of callee children.
REQ-003 SHALL take parameter THREAD, default 16, number of hardware threads.
REQ-004 SHALL take parameter MAX_OUTST, default 4, maximum outstanding calls per thread.
REQ-005 SHALL derive LOG_PARENT, LOG_CHILD and LOG_THREAD as clog2(N), with a minimum of 1; CNT_W SHALL be clog2(MAX_OUTST+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all flops SHALL use the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port parent_req_i, input, PARENT bits: per-parent call request.
REQ-009 SHALL have port parent_child_i, input, LOG_CHILD x [PARENT]: target child of each request.
REQ-010 SHALL have port parent_thread_i, input, LOG_THREAD x [PARENT]: thread of each request.
REQ-011 SHALL have port parent_gnt_o, output, PARENT bits: one-hot combinational grant.
REQ-012 SHALL have port child_rdy_i, input, CHILD bits: child can accept a call.
REQ-013 SHALL have port child_ap_done_i, input, CHILD bits: child finished its call.
REQ-014 SHALL have port ret_vld_i, input, 1 bit: a return was popped by a parent.
REQ-015 SHALL have port ret_thread_i, input, LOG_THREAD bits: thread of that return.
REQ-016 SHALL have ports disp_vld_o, disp_parent_o, disp_child_o and disp_thread_o, outputs, 1/LOG_PARENT/LOG_CHILD/LOG_THREAD bits: registered dispatch.
REQ-017 SHALL have port child_busy_o, output, CHILD bits: per-child busy flags.
REQ-018 SHALL have port ret_underflow_o, output, THREAD bits: sticky per-thread error flags.

Function
REQ-019 SHALL treat parent p as eligible when all of the following hold: parent_req_i[p]; !child_busy[child(p)]; child_rdy_i[child(p)]; outst[thread(p)] < MAX_OUTST.
REQ-020 SHALL grant at most one eligible parent per cycle, chosen round-robin starting from pointer rr_ptr.
REQ-021 SHALL advance rr_ptr to winner+1 (mod PARENT) on a grant, and hold it when there is no grant.
REQ-022 SHALL be grant-combinational: parent_gnt_o SHALL be asserted in the same cycle as the request, and the parent SHALL consume the request on that cycle.
REQ-023 SHALL register the dispatch outputs: disp_vld_o=1 and disp_* SHALL equal the winner's fields exactly 1 cycle after the grant; otherwise disp_vld_o=0 and disp_* SHALL hold their last values.
REQ-024 SHALL, on a grant, set child_busy[child] and increment outst[thread] at the same clock edge.
REQ-025 SHALL clear child_busy[c] on child_ap_done_i[c]; a done for a non-busy child SHALL be ignored.
REQ-026 SHALL, on ret_vld_i, decrement outst[ret_thread_i].
REQ-027 SHALL leave outst unchanged when a grant and a return target the same thread in the same cycle.
REQ-028 SHALL, on a return when outst=0, keep the counter at 0 and set ret_underflow_o[thread] (sticky until reset).
REQ-029 SHALL never let outst exceed MAX_OUTST; eligibility guarantees this, so no saturation logic is needed beyond the eligibility check.
REQ-030 SHALL grant only one of two same-cycle requests for the same child; the loser SHALL see the child busy next cycle.
REQ-031 SHALL allow a child that has done asserted in cycle N to be granted no earlier than cycle N+1.

Reset
REQ-032 SHALL, while rst=1, force the following to 0 asynchronously: rr_ptr, all outst, child_busy, disp_vld_o, disp_*, ret_underflow_o.
REQ-033 SHALL hold parent_gnt_o=0 while rst=1.
REQ-034 SHALL discard any grant that is in flight when reset arrives; no dispatch SHALL appear after reset is released.

Structure
REQ-035 SHALL place the CNT_W helper and a dispatch record typedef (parent, child, thread) in func_arbiter_pkg.
REQ-036 SHALL implement round-robin selection in one sub-module, rr_arbiter (req vector, ptr in; one-hot gnt and index out).

Verification
REQ-037 SHALL cover: parents 0, 3 and 7 request distinct ready children for 3 cycles -> grants 0, 3, 7 in that order, and disp_vld_o lags each grant by 1 cycle.
REQ-038 SHALL cover: parents 1 and 2 both target child 5 -> parent 1 is granted; parent 2 stalls until child_ap_done_i[5] is asserted, then is granted the following cycle.
REQ-039 SHALL cover: thread 4 issues 4 calls to 4 distinct children with MAX_OUTST=4 -> a 5th request is blocked; one ret_vld_i for thread 4 -> the 5th request is granted the next cycle.
REQ-040 SHALL cover: a grant and a return on thread 2 in the same cycle while outst=3 -> outst stays 3.
REQ-041 SHALL cover: ret_vld_i on thread 9 while outst=0 -> ret_underflow_o[9]=1 and the counter stays 0.
REQ-042 SHALL cover: rst asserted the cycle after a grant -> disp_vld_o=0, child_busy_o=0, and no dispatch after release.
